spi_master: RTL



---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_master_if.sv | 19 +
 rtl/spi_clkgen.sv | 29 ++
 rtl/spi_master.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master: FSM states, mode bit positions
// and a constant-foldable ceil(log2) used for counter and select widths.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } state_t;

  localparam int CPOL = 1;
  localparam int CPHA = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host-side register bus of the SPI master: strobes, transfer setup and status.
interface spi_master_if #(
  parameter int DWIDTH = 8,
  parameter int SSW    = 1
);
  logic              cs;
  logic              rd;
  logic              wr;
  logic [DWIDTH-1:0] din;
  logic [1:0]        mode;
  logic [SSW-1:0]    ss_sel;
  logic [DWIDTH-1:0] dout;
  logic              busy;
  logic              done;
  logic              err;

  modport master (output cs, rd, wr, din, mode, ss_sel, input dout, busy, done, err);
  modport slave  (input cs, rd, wr, din, mode, ss_sel, output dout, busy, done, err);
endinterface

// File: rtl/spi_clkgen.sv
// SCLK half-period timer: counts CLKDIV clk cycles and flags the last one.
// A synchronous clear restarts the count so each state starts a full period.
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = (CLKDIV > 1) ? clog2(CLKDIV) : 1;

  logic [CW-1:0] cnt_r;

  assign tick = (cnt_r == CW'(CLKDIV - 1));

  // Half-period counter, wraps on tick
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end
endmodule

// File: rtl/spi_master.sv
// Parametrised SPI master: host strobe bus in, SPI pins out. Four CPOL/CPHA
// modes per transfer, programmable SCLK divider, MSB/LSB order, one-hot selects.
module spi_master
  import spi_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int CLKDIV    = 4,
  parameter int NSS       = 1,
  parameter int LSB_FIRST = 0
) (
  input  logic           clk,
  input  logic           rst,
  spi_master_if.slave    bus,
  output logic           sclk,
  output logic           mosi,
  input  logic           miso,
  output logic [NSS-1:0] ss_n
);
  localparam int SSW = (NSS > 1) ? clog2(NSS) : 1;
  localparam int HW  = clog2(2 * DWIDTH);
  localparam logic [HW-1:0] LAST_HALF = HW'(2 * DWIDTH - 1);

  state_t            state_r, state_nx;
  logic [DWIDTH-1:0] tx_r, rx_r, dout_r;
  logic [HW-1:0]     half_r;
  logic [1:0]        mode_r;
  logic [SSW-1:0]    sel_r;
  logic [NSS-1:0]    ss_n_r;
  logic start_r, busy_r, done_r, err_r, sclk_r, mosi_r;
  logic wr_s, rd_s, accept_s, launch_s, tick_s, clr_s;
  logic edge_s, lead_s, trail_s, shift_s, sample_s, finish_s;

  // An out-of-range index matches no line, so every select stays high.
  function automatic logic [NSS-1:0] ss_mask(input logic [SSW-1:0] sel);
    logic [NSS-1:0] m;
    for (int i = 0; i < NSS; i++) m[i] = (sel != SSW'(i));
    return m;
  endfunction

  assign wr_s     = bus.cs & bus.wr & ~bus.rd;
  assign rd_s     = bus.cs & bus.rd & ~bus.wr;
  assign accept_s = wr_s & ~busy_r & ~start_r;
  assign launch_s = (state_r == IDLE) & start_r;

  spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // Next-state logic and SCLK edge qualification
  always_comb begin
    state_nx = state_r;
    edge_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_r) state_nx = LEAD;
        else state_nx = IDLE;
      end
      LEAD: begin
        if (tick_s) state_nx = XFER;
        else state_nx = LEAD;
      end
      XFER: begin
        edge_s = tick_s;
        if (tick_s && (half_r == LAST_HALF)) state_nx = TRAIL;
        else state_nx = XFER;
      end
      TRAIL: begin
        finish_s = tick_s;
        if (tick_s) state_nx = IDLE;
        else state_nx = TRAIL;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Even half-periods end on a leading edge; CPHA=0 preloads the first bit at launch.
  assign lead_s   = edge_s & ~half_r[0];
  assign trail_s  = edge_s & half_r[0];
  assign sample_s = mode_r[CPHA] ? trail_s : lead_s;
  assign shift_s  = mode_r[CPHA] ? lead_s
                                 : ((trail_s & (half_r != LAST_HALF)) | launch_s);
  assign clr_s    = (state_nx != state_r) | (state_r == IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else state_r <= state_nx;
  end

  // Host handshake, shift registers and SPI pin registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_r    <= '0;
      rx_r    <= '0;
      dout_r  <= '0;
      half_r  <= '0;
      mode_r  <= 2'b00;
      sel_r   <= '0;
      ss_n_r  <= '1;
      start_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      sclk_r  <= 1'b0;
      mosi_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        tx_r    <= bus.din;
        mode_r  <= bus.mode;
        sel_r   <= bus.ss_sel;
        sclk_r  <= bus.mode[CPOL];
        done_r  <= 1'b0;
        start_r <= 1'b1;
      end else if (wr_s) begin
        err_r <= 1'b1;
      end else if (rd_s) begin
        done_r <= 1'b0;
        err_r  <= 1'b0;
      end
      if (launch_s) begin
        start_r <= 1'b0;
        busy_r  <= 1'b1;
        half_r  <= '0;
        ss_n_r  <= ss_mask(sel_r);
      end
      if (shift_s) begin
        if (LSB_FIRST != 0) begin
          mosi_r <= tx_r[0];
          tx_r   <= tx_r >> 1;
        end else begin
          mosi_r <= tx_r[DWIDTH-1];
          tx_r   <= tx_r << 1;
        end
      end
      if (sample_s) begin
        if (LSB_FIRST != 0) rx_r <= {miso, rx_r[DWIDTH-1:1]};
        else rx_r <= {rx_r[DWIDTH-2:0], miso};
      end
      if (edge_s) begin
        sclk_r <= ~sclk_r;
        half_r <= half_r + HW'(1);
      end
      if (finish_s) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
        dout_r <= rx_r;
        ss_n_r <= '1;
      end
    end
  end

  assign bus.dout = dout_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.err  = err_r;
  assign sclk     = sclk_r;
  assign mosi     = mosi_r;
  assign ss_n     = ss_n_r;
endmodule
